fifo_rr_scheduler: RTL and testbench

Round-robin read scheduler for the four-FIFO bank. Watches the FIFOs' empty flags, grants one non-empty FIFO at a time for a burst of up to QUANTUM words, and drives its pop. It forwards the popped word, tagged with its 2-bit source id, to the single downstream consumer. Honours downstream backpressure and rotates priority so that no non-empty FIFO starves.

---
 rtl/fifo_rr_scheduler_pkg.sv | 6 +
 rtl/fifo_rr_scheduler_if.sv | 15 +
 rtl/fifo_rr_scheduler_rr_pick.sv | 16 +
 rtl/fifo_rr_scheduler.sv | 56 +++++
 tb/tb_fifo_rr_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rr_scheduler_pkg.sv
// fifo_rr_scheduler_pkg: shared queue count, id width and FSM encoding for the FIFO-bank scheduler
package fifo_rr_scheduler_pkg;
  localparam int NUM_Q = 4;
  localparam int ID_W = 2;
  typedef enum logic {ST_IDLE, ST_SERVE} state_t;
endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// fifo_rr_scheduler_if: FIFO-bank heads/pops plus the tagged downstream word stream
interface fifo_rr_scheduler_if
  import fifo_rr_scheduler_pkg::*;
#(parameter int DATA_W = 8);
  logic [NUM_Q-1:0] empty;
  logic [NUM_Q-1:0] pop;
  logic [NUM_Q*DATA_W-1:0] fifo_data;
  logic down_full;
  logic [DATA_W-1:0] data_out;
  logic [ID_W-1:0] id;
  logic valid_out;
  logic busy;
  modport master (input empty, fifo_data, down_full, output pop, data_out, id, valid_out, busy);
  modport slave (output empty, fifo_data, down_full, input pop, data_out, id, valid_out, busy);
endinterface

// File: rtl/fifo_rr_scheduler_rr_pick.sv
// rr_pick: rotating-priority encoder, first requester at or after ptr wins
module rr_pick
  import fifo_rr_scheduler_pkg::*;
(
  input  logic [NUM_Q-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);
  always_comb begin
    gnt_id = ptr;
    for (int k = NUM_Q - 1; k >= 0; k--)
      if (req[ptr + ID_W'(k)]) gnt_id = ptr + ID_W'(k);
  end
  assign any = |req;
endmodule

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: grants one non-empty FIFO per burst of up to QUANTUM pops, round-robin
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int QUANTUM = 4
)(
  input logic clk,
  input logic reset,
  fifo_rr_scheduler_if.master bus
);
  localparam int CNT_W = $clog2(QUANTUM) + 1;
  state_t state, state_n;
  logic [ID_W-1:0] cur, cur_n, ptr, ptr_n, gnt_id;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic any, popping;
  rr_pick u_pick (.req(~bus.empty), .ptr(ptr), .gnt_id(gnt_id), .any(any));
  assign popping = state == ST_SERVE && !bus.empty[cur] && !bus.down_full && !reset;
  assign bus.pop = popping ? NUM_Q'(1) << cur : '0;
  assign bus.busy = state == ST_SERVE;
  // a stall holds everything; only an empty head or the last quantum pop hands over
  always_comb begin
    state_n = state;
    cur_n = cur;
    ptr_n = ptr;
    cnt_n = popping ? cnt + 1'b1 : cnt;
    if (state == ST_IDLE) begin
      state_n = any ? ST_SERVE : ST_IDLE;
      cur_n = any ? gnt_id : cur;
      cnt_n = any ? '0 : cnt;
    end else if (bus.empty[cur] || (popping && cnt == CNT_W'(QUANTUM - 1))) begin
      state_n = ST_IDLE;
      ptr_n = cur + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      cur <= '0;
      ptr <= '0;
      cnt <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out <= '0;
      bus.id <= '0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      bus.valid_out <= popping;
      if (popping) begin
        bus.data_out <= bus.fifo_data[cur*DATA_W +: DATA_W];
        bus.id <= cur;
      end
    end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed table plus FIFO-model sequences for the round-robin scheduler
module tb_fifo_rr_scheduler;
  logic clk = 1'b0;
  logic reset;
  int n_run = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  fifo_rr_scheduler_if #(.DATA_W(8)) bus ();
  fifo_rr_scheduler_if #(.DATA_W(8)) bus1 ();
  fifo_rr_scheduler #(.DATA_W(8), .QUANTUM(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  fifo_rr_scheduler #(.DATA_W(8), .QUANTUM(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic rst;
    logic [3:0] empty;
    logic [7:0] head;
    logic df;
    logic [3:0] pop;
    logic busy;
    logic valid;
    logic [7:0] dout;
    logic [1:0] id;
  } vec_t;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } word_t;

  vec_t vecs[$];
  word_t exp_q[$];
  logic [7:0] q[4][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < 4; i++) begin
      bus.empty[i] = q[i].size() == 0;
      bus.fifo_data[i*8 +: 8] = q[i].size() != 0 ? q[i][0] : 8'h00;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    reset = 1'b1;
    bus.empty = 4'hF;
    bus.fifo_data = '0;
    bus.down_full = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    word_t w;
    w.id = id;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic run_model(input string nm, input int ncyc, input logic [63:0] pop_mask,
                           input logic [63:0] df_mask, input logic [63:0] rst_mask);
    int pidx = 0;
    word_t w;
    logic [3:0] ep, seen;
    for (int c = 0; c < ncyc; c++) begin
      drive_heads();
      bus.down_full = df_mask[c];
      reset = rst_mask[c];
      #1;
      w = (pidx < exp_q.size()) ? exp_q[pidx] : '0;
      ep = pop_mask[c] ? (4'b0001 << w.id) : 4'b0000;
      chk($sformatf("%s pop c%0d", nm, c), 32'(bus.pop), 32'(ep));
      seen = bus.pop;
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (seen[i] && q[i].size() != 0) void'(q[i].pop_front());
      chk($sformatf("%s valid c%0d", nm, c), 32'(bus.valid_out), 32'(pop_mask[c]));
      if (pop_mask[c]) begin
        chk($sformatf("%s word c%0d", nm, c), {22'h0, bus.id, bus.data_out}, {22'h0, w});
        pidx++;
      end
    end
    reset = 1'b0;
    bus.down_full = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] m;
    reset = 1'b1;
    bus.empty = 4'hF;
    bus.fifo_data = '0;
    bus.down_full = 1'b0;
    bus1.empty = 4'b1110;
    bus1.fifo_data = 32'h5A;
    bus1.down_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // QUANTUM=1 alternates one IDLE cycle and one pop
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("q1 pop c%0d", c), 32'(bus1.pop), (c % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      chk($sformatf("q1 valid c%0d", c), 32'(bus1.valid_out), (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1) chk($sformatf("q1 word c%0d", c), {22'h0, bus1.id, bus1.data_out}, 32'h05A);
    end

    // single FIFO0 holding A1..A6 with QUANTUM=4
    vecs.push_back('{1'b1, 4'b1110, 8'hA1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA1, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA1, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA1, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA2, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA2, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA3, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA3, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA4, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA4, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA5, 1'b0, 4'h0, 1'b0, 1'b0, 8'hA4, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA5, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA5, 2'd0});
    vecs.push_back('{1'b0, 4'b1110, 8'hA6, 1'b0, 4'h1, 1'b1, 1'b1, 8'hA6, 2'd0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 1'b1, 4'h0, 1'b1, 1'b0, 8'hA6, 2'd0});
    vecs.push_back('{1'b0, 4'b1111, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0, 8'hA6, 2'd0});
    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst;
      bus.empty = vecs[r].empty;
      bus.fifo_data = {24'h0, vecs[r].head};
      bus.down_full = vecs[r].df;
      #1;
      chk($sformatf("tab pop r%0d", r), 32'(bus.pop), 32'(vecs[r].pop));
      chk($sformatf("tab busy r%0d", r), 32'(bus.busy), 32'(vecs[r].busy));
      @(posedge clk); #1;
      chk($sformatf("tab valid r%0d", r), 32'(bus.valid_out), 32'(vecs[r].valid));
      chk($sformatf("tab data r%0d", r), 32'(bus.data_out), 32'(vecs[r].dout));
      chk($sformatf("tab id r%0d", r), 32'(bus.id), 32'(vecs[r].id));
    end
    reset = 1'b0;
    bus.down_full = 1'b0;

    // all four FIFOs with 8 words: 0,1,2,3,0,1,2,3 grants, one bubble each
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(8'(i * 16 + k));
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 4; j++) push_exp(2'(g % 4), 8'((g % 4) * 16 + (g / 4) * 4 + j));
    m = '0;
    for (int c = 0; c < 40; c++) if (c % 5 != 0) m[c] = 1'b1;
    run_model("all4", 42, m, 64'h0, 64'h0);

    // backpressure for 3 cycles after 2 pops; quantum resumes with 2 more
    do_reset();
    for (int k = 0; k < 6; k++) begin
      q[0].push_back(8'(8'hB0 + k));
      push_exp(2'd0, 8'(8'hB0 + k));
    end
    run_model("bp", 13, (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 6) | (64'd1 << 7) | (64'd1 << 9) | (64'd1 << 10),
              (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 5), 64'h0);

    // early empty: FIFO1 moves ptr to 2, FIFO2 has 1 word, FIFO3 has 5
    do_reset();
    q[1].push_back(8'h11);
    q[2].push_back(8'h21);
    for (int k = 0; k < 5; k++) q[3].push_back(8'(8'h30 + k));
    push_exp(2'd1, 8'h11);
    push_exp(2'd2, 8'h21);
    for (int k = 0; k < 5; k++) push_exp(2'd3, 8'(8'h30 + k));
    run_model("early", 15, (64'd1 << 1) | (64'd1 << 4) | (64'd1 << 7) | (64'd1 << 8) | (64'd1 << 9) |
              (64'd1 << 10) | (64'd1 << 12), 64'h0, 64'h0);
    q[0].push_back(8'h01);
    q[1].push_back(8'h12);
    push_exp(2'd0, 8'h01);
    push_exp(2'd1, 8'h12);
    run_model("ptr0", 6, (64'd1 << 1) | (64'd1 << 4), 64'h0, 64'h0);

    // reset on the 2nd pop of FIFO1's burst; ptr must return to 0
    do_reset();
    q[0].push_back(8'hD0);
    for (int k = 0; k < 4; k++) q[1].push_back(8'(8'hE0 + k));
    push_exp(2'd0, 8'hD0);
    push_exp(2'd1, 8'hE0);
    run_model("rst1", 6, (64'd1 << 1) | (64'd1 << 4), 64'h0, 64'd1 << 5);
    chk("rst busy", 32'(bus.busy), 32'd0);
    q[0].push_back(8'hD5);
    push_exp(2'd0, 8'hD5);
    for (int k = 1; k < 4; k++) push_exp(2'd1, 8'(8'hE0 + k));
    run_model("rst2", 9, (64'd1 << 1) | (64'd1 << 4) | (64'd1 << 5) | (64'd1 << 6), 64'h0, 64'h0);

    // wrap: ptr=3 with FIFO3 and FIFO0 pending
    do_reset();
    q[2].push_back(8'h2A);
    push_exp(2'd2, 8'h2A);
    run_model("wrap1", 4, 64'd1 << 1, 64'h0, 64'h0);
    q[3].push_back(8'h3A);
    q[0].push_back(8'h0A);
    push_exp(2'd3, 8'h3A);
    push_exp(2'd0, 8'h0A);
    run_model("wrap2", 6, (64'd1 << 1) | (64'd1 << 4), 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
